// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave round-robin AHB arbiter that holds ownership across bursts, INCR runs and locked sequences.
// Latency: grant is registered one hclk after the request is seen; the data-phase owner follows one accepted address phase later.
// Backpressure: hready=0 freezes grant, owner state, beat counter and data-phase tracking.
module ahb_slave_port_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = $clog2(NUM_MASTERS)
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic [NUM_MASTERS-1:0]   req,
    input  logic [2*NUM_MASTERS-1:0] htrans,
    input  logic [3*NUM_MASTERS-1:0] hburst,
    input  logic [NUM_MASTERS-1:0]   hmastlock,
    input  logic                     hready,
    output logic [NUM_MASTERS-1:0]   grant,
    output logic [ID_W-1:0]          grant_id,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          data_id,
    output logic                     data_valid,
    output logic [ID_W-1:0]          rr_ptr
);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_BURST, ST_LOCK} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t                 state, state_nxt;
    logic [3:0]             beat_cnt, cnt_nxt, burst_len;
    logic [ID_W-1:0]        gid_nxt, rr_nxt, srch_id;
    logic                   gv_nxt, srch_found, rearb, acc;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic [1:0]             otrans;
    logic [2:0]             oburst;
    logic                   olock, oreq;

    // Current owner's transfer controls.
    always_comb begin
        otrans = '0;
        oburst = '0;
        olock  = 1'b0;
        oreq   = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (grant_id == ID_W'(m)) begin
                otrans = htrans[2*m +: 2];
                oburst = hburst[3*m +: 3];
                olock  = hmastlock[m];
                oreq   = req[m];
            end
        end
    end

    // First requester after rr_ptr; the previous owner is checked last.
    always_comb begin
        int idx;
        srch_found = 1'b0;
        srch_id    = rr_ptr;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!srch_found && req[ID_W'(idx)]) begin
                srch_found = 1'b1;
                srch_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        case (oburst)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= ID_W'(NUM_MASTERS - 1);
            beat_cnt    <= '0;
            data_valid  <= 1'b0;
            data_id     <= '0;
        end else if (hready) begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_id    <= gid_nxt;
            grant_valid <= gv_nxt;
            rr_ptr      <= rr_nxt;
            beat_cnt    <= cnt_nxt;
            data_valid  <= grant_valid && otrans[1];
            data_id     <= grant_id;
        end
    end

    always_comb begin
        state_nxt = state;
        gid_nxt   = grant_id;
        gv_nxt    = grant_valid;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        rearb     = 1'b0;
        acc       = hready && otrans[1];
        case (state)
            ST_IDLE: rearb = 1'b1;
            ST_OWN: begin
                if (olock) begin
                    state_nxt = ST_LOCK;
                end else if (otrans == TR_IDLE || !oreq) begin
                    rearb = 1'b1;
                end else if (acc && otrans == TR_NONSEQ && burst_len != 4'd0) begin
                    state_nxt = ST_BURST;
                    cnt_nxt   = burst_len;
                end
            end
            ST_BURST: begin
                if (otrans == TR_IDLE) begin
                    rearb = 1'b1;
                end else if (acc && otrans == TR_SEQ) begin
                    if (beat_cnt <= 4'd1) rearb = 1'b1;
                    else                  cnt_nxt = beat_cnt - 4'd1;
                end
            end
            ST_LOCK: rearb = !olock && otrans == TR_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (rearb) begin
            cnt_nxt = '0;
            if (srch_found) begin
                gid_nxt   = srch_id;
                gv_nxt    = 1'b1;
                rr_nxt    = srch_id;
                state_nxt = ST_OWN;
            end else begin
                gid_nxt   = '0;
                gv_nxt    = 1'b0;
                state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        grant_nxt = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            grant_nxt[m] = gv_nxt && (gid_nxt == ID_W'(m));
        end
    end

endmodule
